// File: rtl/bru_pkg.sv
// Shared types and defaults for the branch resolve unit: the prediction record
// kept per in-flight branch, plus the PC width and fall-through increment.
package bru_pkg;

  localparam int BRU_PCW    = 31;
  localparam int BRU_FT_INC = 2;

  typedef struct packed {
    logic [BRU_PCW-1:0] pc;
    logic               pred_taken;
    logic [BRU_PCW-1:0] pred_target;
  } pred_rec_t;

endpackage

// File: rtl/branch_resolve_unit_if.sv
// Bus between fetch/EX (master) and the branch resolve unit (slave).
// Push handshake: a record transfers on a clk edge where push_valid_i && push_ready_o.
interface branch_resolve_unit_if #(
  parameter int PCW    = bru_pkg::BRU_PCW,
  parameter int QDEPTH = 8
);
  localparam int CW = $clog2(QDEPTH) + 1;

  logic           push_valid_i;
  logic           push_ready_o;
  logic [PCW-1:0] push_pc_i;
  logic           push_pred_taken_i;
  logic [PCW-1:0] push_pred_target_i;

  logic           res_valid_i;
  logic           res_taken_i;
  logic [PCW-1:0] res_target_i;

  logic           feedback_valid_o;
  logic [PCW-1:0] set_pc_o;
  logic           set_taken_o;
  logic [PCW-1:0] set_target_o;
  logic           redirect_valid_o;
  logic [PCW-1:0] redirect_pc_o;
  logic           underflow_err_o;
  logic [CW-1:0]  q_count_o;

  modport master (
    output push_valid_i, push_pc_i, push_pred_taken_i, push_pred_target_i,
    output res_valid_i, res_taken_i, res_target_i,
    input  push_ready_o, feedback_valid_o, set_pc_o, set_taken_o, set_target_o,
    input  redirect_valid_o, redirect_pc_o, underflow_err_o, q_count_o
  );

  modport slave (
    input  push_valid_i, push_pc_i, push_pred_taken_i, push_pred_target_i,
    input  res_valid_i, res_taken_i, res_target_i,
    output push_ready_o, feedback_valid_o, set_pc_o, set_taken_o, set_target_o,
    output redirect_valid_o, redirect_pc_o, underflow_err_o, q_count_o
  );
endinterface

// File: rtl/pred_queue.sv
// Circular FIFO of prediction records with push/pop/flush; pointers carry one
// extra wrap bit and a separate occupancy count is kept.
module pred_queue #(
  parameter int W     = 8,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_valid,
  input  logic [W-1:0]               push_data,
  input  logic                       pop,
  input  logic                       flush,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     count,
  output logic [W-1:0]               head_data
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW:0]   head_ptr;
  logic [AW:0]   tail_ptr;
  logic          push_ok;
  logic          pop_ok;

  assign full      = (count == CW'(DEPTH));
  // A flushing cycle discards the incoming record as wrong-path work.
  assign push_ok   = push_valid && !full && !flush;
  assign pop_ok    = pop && (count != '0);
  assign head_data = mem[head_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else if (flush) begin
      head_ptr <= tail_ptr;
      count    <= '0;
    end else begin
      if (push_ok) tail_ptr <= tail_ptr + 1'b1;
      if (pop_ok)  head_ptr <= head_ptr + 1'b1;
      count <= count + CW'(push_ok) - CW'(pop_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[tail_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Pops the oldest prediction on each EX resolve, updates the predictor and
// redirects fetch on a mispredict. Optional counters under BRU_STATS_EN.
module branch_resolve_unit
  import bru_pkg::*;
#(
  parameter int PCW    = BRU_PCW,
  parameter int QDEPTH = 8,
  parameter int FT_INC = BRU_FT_INC
) (
  input  logic                  clk,
  input  logic                  rst_n,
  branch_resolve_unit_if.slave  bus
`ifdef BRU_STATS_EN
  ,
  output logic [15:0]           stat_branches_o,
  output logic [15:0]           stat_mispred_o
`endif
);
  localparam int CW = $clog2(QDEPTH) + 1;

  pred_rec_t     push_rec;
  pred_rec_t     head_rec;
  logic          full;
  logic [CW-1:0] count;
  logic          do_pop;
  logic          mispredict;
  logic          flush;

  assign push_rec.pc          = bus.push_pc_i;
  assign push_rec.pred_taken  = bus.push_pred_taken_i;
  assign push_rec.pred_target = bus.push_pred_target_i;

  pred_queue #(
    .W     ($bits(pred_rec_t)),
    .DEPTH (QDEPTH)
  ) u_queue (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_valid (bus.push_valid_i),
    .push_data  (push_rec),
    .pop        (do_pop),
    .flush      (flush),
    .full       (full),
    .count      (count),
    .head_data  (head_rec)
  );

  assign do_pop     = bus.res_valid_i && (count != '0);
  assign mispredict = (head_rec.pred_taken != bus.res_taken_i) ||
                      (bus.res_taken_i && (head_rec.pred_target != bus.res_target_i));
  assign flush      = do_pop && mispredict;

  // Ready never credits a same-cycle pop, and is held low while in reset.
  assign bus.push_ready_o = !full && rst_n;
  assign bus.q_count_o    = count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.feedback_valid_o <= 1'b0;
      bus.redirect_valid_o <= 1'b0;
      bus.set_pc_o         <= '0;
      bus.set_taken_o      <= 1'b0;
      bus.set_target_o     <= '0;
      bus.redirect_pc_o    <= '0;
      bus.underflow_err_o  <= 1'b0;
    end else begin
      bus.feedback_valid_o <= do_pop;
      bus.redirect_valid_o <= flush;
      if (do_pop) begin
        bus.set_pc_o      <= head_rec.pc;
        bus.set_taken_o   <= bus.res_taken_i;
        // Not-taken updates rewrite the old predicted target so the BTB keeps it.
        bus.set_target_o  <= bus.res_taken_i ? bus.res_target_i : head_rec.pred_target;
        bus.redirect_pc_o <= bus.res_taken_i ? bus.res_target_i
                                             : head_rec.pc + PCW'(FT_INC);
      end
      if (bus.res_valid_i && (count == '0)) bus.underflow_err_o <= 1'b1;
    end
  end

`ifdef BRU_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_branches_o <= '0;
      stat_mispred_o  <= '0;
    end else begin
      if (do_pop && (stat_branches_o != 16'hFFFF)) stat_branches_o <= stat_branches_o + 16'd1;
      if (flush && (stat_mispred_o != 16'hFFFF))   stat_mispred_o  <= stat_mispred_o + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Bench for branch_resolve_unit: constant vector table plus model-backed
// sequences for flush, full, wrap, underflow and mid-operation reset.
module tb_branch_resolve_unit;
  localparam int PCW    = 31;
  localparam int QDEPTH = 8;

  typedef struct packed {
    logic [PCW-1:0] pc;
    logic           taken;
    logic [PCW-1:0] tgt;
  } rec_t;

  typedef struct packed {
    logic [PCW-1:0] pc;
    logic           taken;
    logic [PCW-1:0] tgt;
    logic           redir;
    logic [PCW-1:0] rpc;
  } exp_t;

  typedef struct {
    rec_t           p;
    logic           rt;
    logic [PCW-1:0] rtgt;
    logic           mis;
    logic [PCW-1:0] stgt;
    logic [PCW-1:0] rpc;
  } vec_t;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;
  logic err_m;
  rec_t model_q[$];
  exp_t exp_q[$];
  vec_t vecs[8];

  branch_resolve_unit_if #(.PCW(PCW), .QDEPTH(QDEPTH)) bus ();

`ifdef BRU_STATS_EN
  logic [15:0] stat_branches;
  logic [15:0] stat_mispred;
`endif

  branch_resolve_unit #(.PCW(PCW), .QDEPTH(QDEPTH), .FT_INC(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef BRU_STATS_EN
    ,
    .stat_branches_o (stat_branches),
    .stat_mispred_o  (stat_mispred)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic pv, input rec_t pr, input logic rv, input logic rt,
                       input logic [PCW-1:0] rtgt);
    bus.push_valid_i       = pv;
    bus.push_pc_i          = pr.pc;
    bus.push_pred_taken_i  = pr.taken;
    bus.push_pred_target_i = pr.tgt;
    bus.res_valid_i        = rv;
    bus.res_taken_i        = rt;
    bus.res_target_i       = rtgt;
  endtask

  // One clock of stimulus; the scoreboard gets an entry whenever a pop is expected.
  task automatic cycle(input logic pv, input rec_t pr, input logic rv, input logic rt,
                       input logic [PCW-1:0] rtgt);
    rec_t h;
    exp_t e;
    logic mis;
    logic push_m;
    logic pop_m;
    drive(pv, pr, rv, rt, rtgt);
    push_m = pv && (model_q.size() < QDEPTH);
    pop_m  = rv && (model_q.size() != 0);
    mis    = 1'b0;
    if (pop_m) begin
      h       = model_q[0];
      mis     = (h.taken != rt) || (rt && (h.tgt != rtgt));
      e.pc    = h.pc;
      e.taken = rt;
      e.tgt   = rt ? rtgt : h.tgt;
      e.redir = mis;
      e.rpc   = rt ? rtgt : h.pc + 31'd2;
      exp_q.push_back(e);
    end
    if (rv && (model_q.size() == 0)) err_m = 1'b1;
    if (mis) model_q.delete();
    else begin
      if (pop_m)  void'(model_q.pop_front());
      if (push_m) model_q.push_back(pr);
    end
    tick();
    if (pop_m) begin
      e = exp_q.pop_front();
      chk("feedback_valid", bus.feedback_valid_o, 1);
      chk("set_pc", bus.set_pc_o, e.pc);
      chk("set_taken", bus.set_taken_o, e.taken);
      chk("set_target", bus.set_target_o, e.tgt);
      chk("redirect_valid", bus.redirect_valid_o, e.redir);
      if (e.redir) chk("redirect_pc", bus.redirect_pc_o, e.rpc);
    end else begin
      chk("feedback_idle", bus.feedback_valid_o, 0);
      chk("redirect_idle", bus.redirect_valid_o, 0);
    end
    chk("q_count", bus.q_count_o, model_q.size());
    chk("push_ready", bus.push_ready_o, model_q.size() != QDEPTH);
    chk("underflow_err", bus.underflow_err_o, err_m);
  endtask

  task automatic idle();
    cycle(1'b0, '0, 1'b0, 1'b0, '0);
  endtask

  task automatic push(input rec_t r);
    cycle(1'b1, r, 1'b0, 1'b0, '0);
  endtask

  task automatic rand_rec(output rec_t r);
    r.pc    = PCW'($urandom);
    r.taken = 1'($urandom_range(0, 1));
    r.tgt   = PCW'($urandom);
  endtask

  // Resolve the head exactly as predicted, optionally pushing in the same cycle.
  task automatic resolve_ok(input logic pv, input rec_t pr);
    rec_t h;
    h = model_q[0];
    cycle(pv, pr, 1'b1, h.taken, h.taken ? h.tgt : PCW'($urandom));
  endtask

  initial begin
    rec_t r;
    n_vec = 0;
    n_err = 0;
    err_m = 1'b0;
    rst_n = 1'b0;
    drive(1'b0, '0, 1'b0, 1'b0, '0);

    vecs[0] = '{'{31'h10,  1'b1, 31'h40},  1'b1, 31'h40,  1'b0, 31'h40,  31'h0};
    vecs[1] = '{'{31'h20,  1'b0, 31'h77},  1'b1, 31'h50,  1'b1, 31'h50,  31'h50};
    vecs[2] = '{'{31'h30,  1'b1, 31'h60},  1'b0, 31'h0,   1'b1, 31'h60,  31'h32};
    vecs[3] = '{'{31'h100, 1'b0, 31'h200}, 1'b0, 31'h999, 1'b0, 31'h200, 31'h0};
    vecs[4] = '{'{31'h104, 1'b1, 31'h300}, 1'b1, 31'h304, 1'b1, 31'h304, 31'h304};
    vecs[5] = '{'{31'h7FFFFFFE, 1'b1, 31'h55}, 1'b0, 31'h0, 1'b1, 31'h55, 31'h0};
    vecs[6] = '{'{31'h500, 1'b1, 31'h600}, 1'b0, 31'h123, 1'b1, 31'h600, 31'h502};
    vecs[7] = '{'{31'h40,  1'b0, 31'h0},   1'b0, 31'h0,   1'b0, 31'h0,   31'h0};

    // reset state
    tick();
    tick();
    chk("rst_feedback", bus.feedback_valid_o, 0);
    chk("rst_redirect", bus.redirect_valid_o, 0);
    chk("rst_count", bus.q_count_o, 0);
    chk("rst_err", bus.underflow_err_o, 0);
    chk("rst_set_pc", bus.set_pc_o, 0);
    chk("rst_redirect_pc", bus.redirect_pc_o, 0);
    rst_n = 1'b1;
    idle();

    // table vectors: push then resolve, compared against fixed expectations
    for (int i = 0; i < 8; i++) begin
      push(vecs[i].p);
      cycle(1'b0, '0, 1'b1, vecs[i].rt, vecs[i].rtgt);
      chk("vec_redirect_valid", bus.redirect_valid_o, vecs[i].mis);
      chk("vec_set_target", bus.set_target_o, vecs[i].stgt);
      chk("vec_set_pc", bus.set_pc_o, vecs[i].p.pc);
      if (vecs[i].mis) chk("vec_redirect_pc", bus.redirect_pc_o, vecs[i].rpc);
      chk("vec_count", bus.q_count_o, 0);
    end

    // flush drops younger records and a push in the flush cycle
    push('{31'h30, 1'b1, 31'h60});
    push('{31'h40, 1'b1, 31'h70});
    push('{31'h50, 1'b0, 31'h80});
    chk("three_queued", bus.q_count_o, 3);
    cycle(1'b1, '{31'h90, 1'b1, 31'h99}, 1'b1, 1'b0, '0);
    chk("flush_rpc", bus.redirect_pc_o, 31'h32);
    chk("flush_tgt", bus.set_target_o, 31'h60);
    chk("flush_count", bus.q_count_o, 0);
    idle();

    // fill to full, push while full, then same-cycle push and pop
    for (int i = 0; i < QDEPTH; i++) begin
      rand_rec(r);
      push(r);
    end
    chk("full_ready", bus.push_ready_o, 0);
    rand_rec(r);
    push(r);
    chk("full_count", bus.q_count_o, 8);
    resolve_ok(1'b0, '0);
    rand_rec(r);
    resolve_ok(1'b1, r);
    chk("pushpop_count", bus.q_count_o, 7);

    // pointer wrap across 20 push+pop cycles
    for (int i = 0; i < 20; i++) begin
      rand_rec(r);
      resolve_ok(1'b1, r);
    end
    while (model_q.size() > 0) resolve_ok(1'b0, '0);
    idle();

    // underflow is sticky
    cycle(1'b0, '0, 1'b1, 1'b1, 31'h5);
    chk("underflow_set", bus.underflow_err_o, 1);
    idle();
    push('{31'h80, 1'b1, 31'h88});
    resolve_ok(1'b0, '0);
    chk("underflow_sticky", bus.underflow_err_o, 1);

    // reset with five records queued and a resolve pending
    for (int i = 0; i < 5; i++) begin
      rand_rec(r);
      push(r);
    end
    rst_n = 1'b0;
    drive(1'b1, '{31'h11, 1'b0, 31'h22}, 1'b1, 1'b1, 31'h33);
    tick();
    chk("midrst_count", bus.q_count_o, 0);
    chk("midrst_feedback", bus.feedback_valid_o, 0);
    chk("midrst_redirect", bus.redirect_valid_o, 0);
    chk("midrst_err", bus.underflow_err_o, 0);
    chk("midrst_ready", bus.push_ready_o, 0);
    model_q.delete();
    err_m = 1'b0;
    rst_n = 1'b1;
    idle();
    idle();

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Downstream partner of the BTB/BHT predictor. Fetch pushes one prediction record (PC, predicted taken, predicted target) for each branch it sends down the pipe.
- When EX resolves a branch, the block pops the oldest record and compares prediction against outcome.
- It drives the predictor's correction port (feedback_valid/set_pc/set_taken/set_target) and a fetch redirect + flush on a mispredict.
- Sits between the EX stage and the fetch/predictor logic.

Parameters:
- PCW, 31, width of a valid PC; matches the predictor.
- QDEPTH, 8, prediction queue depth; power of two, ≥2.
- FT_INC, 2, fall-through increment in PC units (one 32-bit instruction).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset
- push_valid_i  in  1  fetch offers a prediction record
- push_ready_o  out  1  queue can accept a record
- push_pc_i  in  PCW  branch PC
- push_pred_taken_i  in  1  predicted direction
- push_pred_target_i  in  PCW  predicted target
- res_valid_i  in  1  EX resolves the oldest in-flight branch this cycle
- res_taken_i  in  1  actual direction
- res_target_i  in  PCW  actual taken target
- feedback_valid_o  out  1  predictor update strobe
- set_pc_o  out  PCW  PC to update
- set_taken_o  out  1  actual direction
- set_target_o  out  PCW  target written to the BTB
- redirect_valid_o  out  1  mispredict redirect strobe; fetch also flushes younger work
- redirect_pc_o  out  PCW  correct next PC
- underflow_err_o  out  1  sticky error flag
- q_count_o  out  $clog2(QDEPTH)+1  occupancy

Behaviour:
- Reset: rst_n is synchronous, active-low, on clk.
  - All outputs are 0 and the queue is empty.
  - Reset mid-operation discards all records and any pending strobe on the next edge.
- Queue: circular FIFO with head/tail pointers one bit wider than the index, plus a count.
  - push_ready_o = (count != QDEPTH). It does not credit a same-cycle pop.
  - A push is accepted when push_valid_i && push_ready_o.
  - Push and pop in the same cycle leave count unchanged.
- Resolve: when res_valid_i and count > 0, the head record is popped that cycle.
  - mispredict = (pred_taken != res_taken_i) || (res_taken_i && pred_target != res_target_i).
- Latency: every output is registered, so strobes appear exactly 1 cycle after res_valid_i and last one cycle.
  - feedback_valid_o = 1.
  - set_pc_o = head pc.
  - set_taken_o = res_taken_i.
  - set_target_o = res_taken_i ? res_target_i : head pred_target. This keeps the BTB target on a not-taken update.
  - redirect_valid_o = mispredict.
  - redirect_pc_o = res_taken_i ? res_target_i : head pc + FT_INC, wrapping modulo 2^PCW.
  - Non-strobe outputs hold their last value when idle.
- Flush: on mispredict, the queue empties at the same edge (head = tail, count = 0).
  - A push in that same cycle is dropped (wrong path); push_ready_o stays as computed.
- Underflow: res_valid_i with count == 0 produces no strobes and sets underflow_err_o. Only reset clears it.
- Correctly predicted branches give feedback only; no redirect.

Optional Feature:
- Macro BRU_STATS_EN.
- When defined, adds outputs stat_branches_o[15:0] and stat_mispred_o[15:0]. These saturating counters increment on each valid pop and each mispredict; reset clears them to 0.
- When not defined, the ports and logic are absent.

Decomposition:
- Package bru_pkg holds:
  - the pred_rec_t struct (pc, pred_taken, pred_target);
  - the PCW default;
  - the FT_INC default.
- Sub-module pred_queue: parameterised FIFO with push/pop/flush, full/count outputs, and a head-record output.

Test Plan:
- Push {pc=0x10, taken=1, tgt=0x40}, resolve taken tgt=0x40 → next cycle: feedback_valid_o=1, set_pc_o=0x10, set_target_o=0x40, redirect_valid_o=0; count 1→0.
- Push {0x20, taken=0, tgt=0x77}, resolve taken tgt=0x50 → redirect_valid_o=1, redirect_pc_o=0x50, set_target_o=0x50; queue flushed.
- Push {0x30, taken=1, tgt=0x60}, then two more records, resolve not-taken → redirect_pc_o=0x32, set_target_o=0x60, count=0; a push in the flush cycle is dropped.
- Fill 8 records → push_ready_o=0. Then push+resolve correct in the same cycle while not full → count unchanged. Pointers wrap correctly across 20 pushes/pops.
- res_valid_i with an empty queue → no strobes, underflow_err_o=1, sticky until rst_n=0.
- Assert rst_n=0 with 5 records queued and a resolve pending → after the edge, count=0, all strobes 0, underflow_err_o=0.
